data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Load/store unit between a CPU and a word-wide data memory: sizes, lanes, sign extension, wait states.
// Define DATA_MEM_CTRL_ALIGN_CHECK_EN to flag misaligned accesses instead of masking their low address bits.
module data_mem_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_cpuReq,
  input  logic                  i_cpuWrEnable,
  input  logic [ADDR_WIDTH-1:0] i_cpuAddr,
  input  logic [DATA_WIDTH-1:0] i_cpuWrData,
  input  logic [1:0]            i_cpuAccess,
  input  logic                  i_cpuUnsigned,
  output logic [DATA_WIDTH-1:0] o_cpuRdData,
  output logic                  o_cpuReady,
  output logic                  o_cpuBusy,
  output logic                  o_cpuError,
  output logic [ADDR_WIDTH-1:0] o_memAddr,
  output logic [DATA_WIDTH-1:0] o_memWrData,
  output logic [3:0]            o_memByteEnable,
  output logic                  o_memWrEnable,
  output logic                  o_memRdEnable,
  input  logic [DATA_WIDTH-1:0] i_memRdData
);

  localparam int         WAIT_INIT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [2:0] WAIT_LOAD = WAIT_INIT[2:0];

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wrData_q, rdData_q;
  logic [1:0]            size_q;
  logic                  wr_q, uns_q;

  logic [ADDR_WIDTH-1:0] alignedAddr;
  logic [DATA_WIDTH-1:0] laneWord, loadVal;
  logic                  accept, misaligned, loadDone;

  assign accept      = (state_q == IDLE) && i_cpuReq;
  assign loadDone    = !wr_q && (state_d == DONE) && ((state_q == ACCESS) || (state_q == WAIT));
  assign o_cpuRdData = rdData_q;

  // Low address bits are forced to natural alignment; aligned requests pass through untouched.
  always_comb begin
    alignedAddr = i_cpuAddr;
    if (i_cpuAccess == 2'b01) begin
      alignedAddr[0] = 1'b0;
    end else if (i_cpuAccess != 2'b00) begin
      alignedAddr[1:0] = 2'b00;
    end
  end

`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
  logic err_q;

  assign misaligned = (i_cpuAccess == 2'b01) ? i_cpuAddr[0]
                    : ((i_cpuAccess != 2'b00) && (i_cpuAddr[1:0] != 2'b00));
  assign o_cpuError = (state_q == DONE) && err_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misaligned;
    end
  end
`else
  assign misaligned = 1'b0;
  assign o_cpuError = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      addr_q   <= '0;
      wrData_q <= '0;
      rdData_q <= '0;
      size_q   <= 2'b00;
      wr_q     <= 1'b0;
      uns_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q   <= alignedAddr;
        wrData_q <= i_cpuWrData;
        size_q   <= i_cpuAccess;
        wr_q     <= i_cpuWrEnable;
        uns_q    <= i_cpuUnsigned;
      end
      if (loadDone) begin
        rdData_q <= loadVal;
      end
    end
  end

  // Shifting the read word down by the byte offset puts the addressed lane at bit 0.
  always_comb begin
    laneWord = i_memRdData >> {addr_q[1:0], 3'b000};
    loadVal  = i_memRdData;
    if (size_q == 2'b00) begin
      loadVal = {{24{~uns_q & laneWord[7]}}, laneWord[7:0]};
    end else if (size_q == 2'b01) begin
      loadVal = {{16{~uns_q & laneWord[15]}}, laneWord[15:0]};
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    o_cpuReady      = (state_q == DONE);
    o_cpuBusy       = (state_q != IDLE);
    o_memAddr       = '0;
    o_memWrData     = '0;
    o_memByteEnable = 4'b0000;
    o_memWrEnable   = 1'b0;
    o_memRdEnable   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_cpuReq) state_d = misaligned ? DONE : ACCESS;
      end
      ACCESS: begin
        o_memAddr     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        o_memWrEnable = wr_q;
        o_memRdEnable = !wr_q;
        case (size_q)
          2'b00: begin
            o_memByteEnable = 4'b0001 << addr_q[1:0];
            o_memWrData     = {4{wrData_q[7:0]}};
          end
          2'b01: begin
            o_memByteEnable = addr_q[1] ? 4'b1100 : 4'b0011;
            o_memWrData     = {2{wrData_q[15:0]}};
          end
          default: begin
            o_memByteEnable = 4'b1111;
            o_memWrData     = wrData_q;
          end
        endcase
        if (WAIT_STATES > 0) begin
          state_d = WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = DONE;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances (WAIT_STATES 0, 1, 3) share the CPU and memory inputs.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_data_mem_ctrl;

  logic        clock = 1'b0;
  logic        rstN;
  logic        req, wrEn, uns;
  logic [31:0] addr, wrData, memRdData;
  logic [1:0]  access;

  logic [31:0] rdData0, memAddr0, memWrData0;
  logic [31:0] rdData1, memAddr1, memWrData1;
  logic [31:0] rdData3, memAddr3, memWrData3;
  logic [3:0]  be0, be1, be3;
  logic        ready0, busy0, err0, memWr0, memRd0;
  logic        ready1, busy1, err1, memWr1, memRd1;
  logic        ready3, busy3, err3, memWr3, memRd3;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  data_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_STATES(0)) dut0 (
    .i_clock(clock), .i_reset(rstN), .i_cpuReq(req), .i_cpuWrEnable(wrEn), .i_cpuAddr(addr),
    .i_cpuWrData(wrData), .i_cpuAccess(access), .i_cpuUnsigned(uns), .o_cpuRdData(rdData0),
    .o_cpuReady(ready0), .o_cpuBusy(busy0), .o_cpuError(err0), .o_memAddr(memAddr0),
    .o_memWrData(memWrData0), .o_memByteEnable(be0), .o_memWrEnable(memWr0),
    .o_memRdEnable(memRd0), .i_memRdData(memRdData));

  data_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_STATES(1)) dut1 (
    .i_clock(clock), .i_reset(rstN), .i_cpuReq(req), .i_cpuWrEnable(wrEn), .i_cpuAddr(addr),
    .i_cpuWrData(wrData), .i_cpuAccess(access), .i_cpuUnsigned(uns), .o_cpuRdData(rdData1),
    .o_cpuReady(ready1), .o_cpuBusy(busy1), .o_cpuError(err1), .o_memAddr(memAddr1),
    .o_memWrData(memWrData1), .o_memByteEnable(be1), .o_memWrEnable(memWr1),
    .o_memRdEnable(memRd1), .i_memRdData(memRdData));

  data_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_STATES(3)) dut3 (
    .i_clock(clock), .i_reset(rstN), .i_cpuReq(req), .i_cpuWrEnable(wrEn), .i_cpuAddr(addr),
    .i_cpuWrData(wrData), .i_cpuAccess(access), .i_cpuUnsigned(uns), .o_cpuRdData(rdData3),
    .o_cpuReady(ready3), .o_cpuBusy(busy3), .o_cpuError(err3), .o_memAddr(memAddr3),
    .o_memWrData(memWrData3), .o_memByteEnable(be3), .o_memWrEnable(memWr3),
    .o_memRdEnable(memRd3), .i_memRdData(memRdData));

  task automatic doReset();
    rstN = 1'b0;
    req  = 1'b0;
    repeat (2) @(negedge clock);
    rstN = 1'b1;
  endtask

  // Issues one request to all instances and follows dut1 until its ready pulse (bounded), then one idle cycle.
  task automatic runReq(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                        input logic u, input logic rel, output int lat, output int strobes,
                        output logic [31:0] sAddr, output logic [31:0] sData, output logic [3:0] sBe,
                        output logic sErr);
    @(negedge clock);
    if (rel) rstN = 1'b1;
    wrEn = w; addr = a; wrData = d; access = sz; uns = u; req = 1'b1;
    lat = -1; strobes = 0; sAddr = '0; sData = '0; sBe = '0; sErr = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (memWr1 || memRd1) begin
        strobes++;
        sAddr = memAddr1; sData = memWrData1; sBe = be1;
      end
      if (ready1) begin
        lat = i; sErr = err1;
        break;
      end
    end
    req = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    req = 1'b1; wrEn = 1'b1; addr = 32'h100; access = 2'b10;
    repeat (2) @(negedge clock);
    checks++; if (busy1 !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy1); else passed++;
    checks++; if (ready1 !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", ready1); else passed++;
    checks++; if (rdData1 !== 32'h0) $display("[TB] FAIL reset_rdData: got %h expected 00000000", rdData1); else passed++;
    checks++; if ({memWr1, memRd1, be1} !== 6'b0) $display("[TB] FAIL reset_strobes: got %b expected 000000", {memWr1, memRd1, be1}); else passed++;
    checks++; if (memAddr1 !== 32'h0) $display("[TB] FAIL reset_memAddr: got %h expected 00000000", memAddr1); else passed++;
    checks++; if (err1 !== 1'b0) $display("[TB] FAIL reset_error: got %b expected 0", err1); else passed++;
    req = 1'b0;
    rstN = 1'b1;
  endtask

  task automatic test_store_word();
    int lat, strobes; logic [31:0] sAddr, sData; logic [3:0] sBe; logic sErr;
    doReset();
    runReq(1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, lat, strobes, sAddr, sData, sBe, sErr);
    checks++; if (lat !== 3) $display("[TB] FAIL sw_latency: got %0d expected 3", lat); else passed++;
    checks++; if (strobes !== 1) $display("[TB] FAIL sw_strobes: got %0d expected 1", strobes); else passed++;
    checks++; if (sAddr !== 32'h100) $display("[TB] FAIL sw_addr: got %h expected 00000100", sAddr); else passed++;
    checks++; if (sBe !== 4'b1111) $display("[TB] FAIL sw_be: got %b expected 1111", sBe); else passed++;
    checks++; if (sData !== 32'hDEADBEEF) $display("[TB] FAIL sw_data: got %h expected deadbeef", sData); else passed++;
    checks++; if (sErr !== 1'b0) $display("[TB] FAIL sw_error: got %b expected 0", sErr); else passed++;
    checks++; if (busy1 !== 1'b0) $display("[TB] FAIL sw_idle_busy: got %b expected 0", busy1); else passed++;
  endtask

  task automatic test_loads();
    int lat, strobes; logic [31:0] sAddr, sData; logic [3:0] sBe; logic sErr;
    doReset();
    memRdData = 32'h80FF0000;
    runReq(1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 1'b0, lat, strobes, sAddr, sData, sBe, sErr);
    checks++; if (rdData1 !== 32'hFFFFFF80) $display("[TB] FAIL lb_signed: got %h expected ffffff80", rdData1); else passed++;
    checks++; if (sBe !== 4'b1000) $display("[TB] FAIL lb_be: got %b expected 1000", sBe); else passed++;
    checks++; if (sAddr !== 32'h100) $display("[TB] FAIL lb_addr: got %h expected 00000100", sAddr); else passed++;
    runReq(1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 1'b0, lat, strobes, sAddr, sData, sBe, sErr);
    checks++; if (rdData1 !== 32'h00000080) $display("[TB] FAIL lb_unsigned: got %h expected 00000080", rdData1); else passed++;
    runReq(1'b0, 32'h102, 32'h0, 2'b01, 1'b0, 1'b0, lat, strobes, sAddr, sData, sBe, sErr);
    checks++; if (rdData1 !== 32'hFFFF80FF) $display("[TB] FAIL lh_signed: got %h expected ffff80ff", rdData1); else passed++;
    memRdData = 32'h12345678;
    runReq(1'b0, 32'h104, 32'h0, 2'b11, 1'b0, 1'b0, lat, strobes, sAddr, sData, sBe, sErr);
    checks++; if (rdData1 !== 32'h12345678) $display("[TB] FAIL lw_data: got %h expected 12345678", rdData1); else passed++;
    checks++; if ({sAddr, sBe} !== {32'h104, 4'b1111}) $display("[TB] FAIL lw_addr_be: got %h/%b expected 00000104/1111", sAddr, sBe); else passed++;
  endtask

  task automatic test_stores();
    int lat, strobes; logic [31:0] sAddr, sData; logic [3:0] sBe; logic sErr;
    doReset();
    memRdData = 32'h0BADF00D;
    runReq(1'b0, 32'h200, 32'h0, 2'b10, 1'b0, 1'b0, lat, strobes, sAddr, sData, sBe, sErr);
    runReq(1'b1, 32'h102, 32'hFFFF1234, 2'b01, 1'b0, 1'b0, lat, strobes, sAddr, sData, sBe, sErr);
    checks++; if (sBe !== 4'b1100) $display("[TB] FAIL sh_be: got %b expected 1100", sBe); else passed++;
    checks++; if (sData !== 32'h12341234) $display("[TB] FAIL sh_data: got %h expected 12341234", sData); else passed++;
    checks++; if (sAddr !== 32'h100) $display("[TB] FAIL sh_addr: got %h expected 00000100", sAddr); else passed++;
    checks++; if (rdData1 !== 32'h0BADF00D) $display("[TB] FAIL store_keeps_rdData: got %h expected 0badf00d", rdData1); else passed++;
    runReq(1'b1, 32'h101, 32'hFFFFFFAB, 2'b00, 1'b0, 1'b0, lat, strobes, sAddr, sData, sBe, sErr);
    checks++; if ({sBe, sData} !== {4'b0010, 32'hABABABAB}) $display("[TB] FAIL sb_be_data: got %b/%h expected 0010/abababab", sBe, sData); else passed++;
    runReq(1'b1, 32'h100, 32'h00005678, 2'b01, 1'b0, 1'b0, lat, strobes, sAddr, sData, sBe, sErr);
    checks++; if ({sBe, sData} !== {4'b0011, 32'h56785678}) $display("[TB] FAIL sh_low_be_data: got %b/%h expected 0011/56785678", sBe, sData); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r0, b0, r1, b1, r3, b3, er0, eb0, er1, eb1, er3, eb3;
    r0 = '0; b0 = '0; r1 = '0; b1 = '0; r3 = '0; b3 = '0;
    er0 = '0; eb0 = '0; er1 = '0; eb1 = '0; er3 = '0; eb3 = '0;
    for (int i = 1; i <= 30; i++) begin
      er0[i] = (i % 3 == 2); eb0[i] = (i % 3 != 0);
      er1[i] = (i % 4 == 3); eb1[i] = (i % 4 != 0);
      er3[i] = (i % 6 == 5); eb3[i] = (i % 6 != 0);
    end
    doReset();
    memRdData = 32'h01020304;
    @(negedge clock);
    wrEn = 1'b0; addr = 32'h200; access = 2'b10; uns = 1'b0; req = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      r0[i] = ready0; b0[i] = busy0;
      r1[i] = ready1; b1[i] = busy1;
      r3[i] = ready3; b3[i] = busy3;
    end
    req = 1'b0;
    checks++; if (r0 !== er0) $display("[TB] FAIL b2b_ready_ws0: got %h expected %h", r0, er0); else passed++;
    checks++; if (b0 !== eb0) $display("[TB] FAIL b2b_busy_ws0: got %h expected %h", b0, eb0); else passed++;
    checks++; if (r1 !== er1) $display("[TB] FAIL b2b_ready_ws1: got %h expected %h", r1, er1); else passed++;
    checks++; if (b1 !== eb1) $display("[TB] FAIL b2b_busy_ws1: got %h expected %h", b1, eb1); else passed++;
    checks++; if (r3 !== er3) $display("[TB] FAIL b2b_ready_ws3: got %h expected %h", r3, er3); else passed++;
    checks++; if (b3 !== eb3) $display("[TB] FAIL b2b_busy_ws3: got %h expected %h", b3, eb3); else passed++;
    checks++; if (rdData0 !== 32'h01020304) $display("[TB] FAIL b2b_rdData_ws0: got %h expected 01020304", rdData0); else passed++;
  endtask

  task automatic test_reset_mid_access();
    int lat, strobes, readies; logic [31:0] sAddr, sData; logic [3:0] sBe; logic sErr;
    doReset();
    memRdData = 32'h55AA55AA;
    runReq(1'b0, 32'h300, 32'h0, 2'b10, 1'b0, 1'b0, lat, strobes, sAddr, sData, sBe, sErr);
    checks++; if (rdData1 !== 32'h55AA55AA) $display("[TB] FAIL mid_pre_load: got %h expected 55aa55aa", rdData1); else passed++;
    @(negedge clock);
    wrEn = 1'b0; addr = 32'h304; access = 2'b10; req = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if ({busy1, busy3} !== 2'b11) $display("[TB] FAIL mid_in_wait_busy: got %b expected 11", {busy1, busy3}); else passed++;
    rstN = 1'b0;
    req = 1'b0;
    #1;
    checks++; if ({busy1, busy3, ready1, ready3} !== 4'b0) $display("[TB] FAIL mid_abort_busy_ready: got %b expected 0000", {busy1, busy3, ready1, ready3}); else passed++;
    checks++; if ({memRd1, memRd3, memWr1, memWr3} !== 4'b0) $display("[TB] FAIL mid_abort_strobes: got %b expected 0000", {memRd1, memRd3, memWr1, memWr3}); else passed++;
    checks++; if (rdData1 !== 32'h0) $display("[TB] FAIL mid_abort_rdData: got %h expected 00000000", rdData1); else passed++;
    repeat (2) @(negedge clock);
    rstN = 1'b1;
    readies = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (ready1 || ready3 || busy1 || busy3) readies++;
    end
    checks++; if (readies !== 0) $display("[TB] FAIL mid_no_completion: got %0d active cycles expected 0", readies); else passed++;
    rstN = 1'b0;
    memRdData = 32'hCAFEF00D;
    runReq(1'b0, 32'h304, 32'h0, 2'b10, 1'b0, 1'b1, lat, strobes, sAddr, sData, sBe, sErr);
    checks++; if (lat !== 3) $display("[TB] FAIL mid_first_req_latency: got %0d expected 3", lat); else passed++;
    checks++; if (rdData1 !== 32'hCAFEF00D) $display("[TB] FAIL mid_after_reset_load: got %h expected cafef00d", rdData1); else passed++;
  endtask

  task automatic test_alignment();
    int lat, strobes; logic [31:0] sAddr, sData; logic [3:0] sBe; logic sErr;
    doReset();
    memRdData = 32'hA5A5A5A5;
    runReq(1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 1'b0, lat, strobes, sAddr, sData, sBe, sErr);
    checks++; if (rdData1 !== 32'hA5A5A5A5) $display("[TB] FAIL align_pre_load: got %h expected a5a5a5a5", rdData1); else passed++;
    memRdData = 32'h11223344;
    runReq(1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 1'b0, lat, strobes, sAddr, sData, sBe, sErr);
`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
    checks++; if (lat !== 1) $display("[TB] FAIL align_lw_latency: got %0d expected 1", lat); else passed++;
    checks++; if (strobes !== 0) $display("[TB] FAIL align_lw_strobes: got %0d expected 0", strobes); else passed++;
    checks++; if (sErr !== 1'b1) $display("[TB] FAIL align_lw_error: got %b expected 1", sErr); else passed++;
    checks++; if (rdData1 !== 32'hA5A5A5A5) $display("[TB] FAIL align_lw_rdData: got %h expected a5a5a5a5", rdData1); else passed++;
`else
    checks++; if (lat !== 3) $display("[TB] FAIL align_lw_latency: got %0d expected 3", lat); else passed++;
    checks++; if ({sAddr, sBe} !== {32'h100, 4'b1111}) $display("[TB] FAIL align_lw_addr_be: got %h/%b expected 00000100/1111", sAddr, sBe); else passed++;
    checks++; if (sErr !== 1'b0) $display("[TB] FAIL align_lw_error: got %b expected 0", sErr); else passed++;
    checks++; if (rdData1 !== 32'h11223344) $display("[TB] FAIL align_lw_rdData: got %h expected 11223344", rdData1); else passed++;
`endif
    checks++; if (err1 !== 1'b0) $display("[TB] FAIL align_error_drops: got %b expected 0", err1); else passed++;
    runReq(1'b1, 32'h103, 32'h0000BEEF, 2'b01, 1'b0, 1'b0, lat, strobes, sAddr, sData, sBe, sErr);
`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
    checks++; if ({lat, strobes} !== {32'd1, 32'd0}) $display("[TB] FAIL align_sh_lat_strobes: got %0d/%0d expected 1/0", lat, strobes); else passed++;
    checks++; if (sErr !== 1'b1) $display("[TB] FAIL align_sh_error: got %b expected 1", sErr); else passed++;
`else
    checks++; if ({sAddr, sBe} !== {32'h100, 4'b1100}) $display("[TB] FAIL align_sh_addr_be: got %h/%b expected 00000100/1100", sAddr, sBe); else passed++;
    checks++; if (sData !== 32'hBEEFBEEF) $display("[TB] FAIL align_sh_data: got %h expected beefbeef", sData); else passed++;
`endif
  endtask

  initial begin
    rstN = 1'b0; req = 1'b0; wrEn = 1'b0; uns = 1'b0;
    addr = '0; wrData = '0; access = 2'b00; memRdData = '0;
    test_reset();
    test_store_word();
    test_loads();
    test_stores();
    test_back_to_back();
    test_reset_mid_access();
    test_alignment();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
